// File: rtl/multiplicador_pkg.sv
// Shared types and helpers for the sequential fixed-point multiplier.
// Holds the FSM state enum and the output saturation-limit helpers.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_t;

    // Largest value representable in wo bits, returned right-aligned
    // in 64 bits. Signed ranges give up one bit to the sign.
    function automatic logic [63:0] sat_max(input int wo, input bit sgn);
        logic [63:0] v;
        v = '1;
        v = v >> (64 - wo + (sgn ? 1 : 0));
        return v;
    endfunction

    // Smallest value representable in wo bits (two's complement when
    // signed); only the low wo bits are meaningful.
    function automatic logic [63:0] sat_min(input int wo, input bit sgn);
        return sgn ? ~sat_max(wo, sgn) : 64'd0;
    endfunction

endpackage

// File: rtl/multiplicador_secuencial_if.sv
// Upstream/downstream valid-ready bundle for the sequential multiplier.
// Ports: in1/in2/in_valid/in_ready (operands), out/ovf/out_valid/out_ready (result).
interface multiplicador_secuencial_if #(
    parameter int W1 = 24,
    parameter int W2 = 12,
    parameter int WO = 12
);
    logic [W1-1:0] in1;
    logic [W2-1:0] in2;
    logic          in_valid;
    logic          in_ready;
    logic [WO-1:0] out;
    logic          ovf;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in1, in2, in_valid, out_ready,
        input  in_ready, out, ovf, out_valid
    );

    modport slave (
        input  in1, in2, in_valid, out_ready,
        output in_ready, out, ovf, out_valid
    );
endinterface

// File: rtl/multiplicador_sat.sv
// Combinational fixed-point rescale: optional round-half-up, right shift,
// then saturate or wrap to WO bits. Ports: i_p (product), o_res, o_ovf.
module multiplicador_sat
    import multiplicador_pkg::*;
#(
    parameter int WP     = 36,
    parameter int WO     = 12,
    parameter int SHIFT  = 12,
    parameter int SIGNED = 1,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic [WP-1:0] i_p,
    output logic [WO-1:0] o_res,
    output logic          o_ovf
);
    // One guard bit above the product so the rounding add cannot overflow.
    localparam int WG = WP + 1;

    // (1 << SHIFT) >> 1 is 2^(SHIFT-1), and collapses to 0 when SHIFT=0.
    localparam logic [WG-1:0] RC =
        (ROUND != 0) ? ((WG'(1) << SHIFT) >> 1) : '0;

    localparam logic [WO-1:0] MAXV = WO'(sat_max(WO, SIGNED != 0));
    localparam logic [WO-1:0] MINV = WO'(sat_min(WO, SIGNED != 0));

    logic               w_sx;
    logic [WG-1:0]      w_ext;
    logic [WG-1:0]      w_sum;
    logic signed [WG-1:0] w_rs;
    logic [WG-1:0]      w_ru;
    logic [WG-1:0]      w_r;
    logic               w_fit_s;
    logic               w_fit_u;
    logic               w_fits;

    always_comb begin
        w_sx  = (SIGNED != 0) ? i_p[WP-1] : 1'b0;
        w_ext = {w_sx, i_p};
        w_sum = w_ext + RC;
        // Kept in separate signed/unsigned nets so the arithmetic shift
        // is not turned logical by a mixed-sign conditional.
        w_rs  = $signed(w_sum) >>> SHIFT;
        w_ru  = w_sum >> SHIFT;
        w_r   = (SIGNED != 0) ? w_rs : w_ru;

        // In range when the bits above the kept field are pure extension.
        w_fit_s = (&w_r[WG-1:WO-1]) | ~(|w_r[WG-1:WO-1]);
        w_fit_u = ~(|w_r[WG-1:WO]);
        w_fits  = (SIGNED != 0) ? w_fit_s : w_fit_u;

        o_res = w_r[WO-1:0];
        o_ovf = 1'b0;
        if (!w_fits) begin
            o_ovf = 1'b1;
            if (SAT != 0) begin
                if ((SIGNED != 0) && w_r[WG-1]) begin
                    o_res = MINV;
                end else begin
                    o_res = MAXV;
                end
            end
        end
    end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Radix-2 shift-add fixed-point multiplier with valid/ready handshakes.
// Ports: clk, rst (sync, active-high), io_bus (operands in, result out).
module multiplicador_secuencial
    import multiplicador_pkg::*;
#(
    parameter int W1     = 24,
    parameter int W2     = 12,
    parameter int WO     = 12,
    parameter int SHIFT  = 12,
    parameter int SIGNED = 1,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic clk,
    input  logic rst,
    multiplicador_secuencial_if.slave io_bus
);
    localparam int WP = W1 + W2;
    localparam int CW = (W2 > 1) ? $clog2(W2) : 1;

    state_t        r_state;
    logic [WP-1:0] r_mcand;
    logic [W2-1:0] r_mplier;
    logic [WP-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [WO-1:0] r_out;
    logic          r_ovf;
    logic          r_in_ready;
    logic          r_out_valid;

    logic          w_sx;
    logic [WP-1:0] w_mext;
    logic [WP-1:0] w_addend;
    logic          w_last;
    logic [WP-1:0] w_acc_nxt;
    logic [WO-1:0] w_res;
    logic          w_ovf;

    always_comb begin
        w_sx     = (SIGNED != 0) ? io_bus.in1[W1-1] : 1'b0;
        w_mext   = {{W2{w_sx}}, io_bus.in1};
        w_addend = r_mcand << r_cnt;
        w_last   = (r_cnt == CW'(W2 - 1));
        w_acc_nxt = r_acc;
        if (r_mplier[0]) begin
            // Signed MSB carries weight -2^(W2-1): subtract its partial product.
            if (w_last && (SIGNED != 0)) begin
                w_acc_nxt = r_acc - w_addend;
            end else begin
                w_acc_nxt = r_acc + w_addend;
            end
        end
    end

    multiplicador_sat #(
        .WP     (WP),
        .WO     (WO),
        .SHIFT  (SHIFT),
        .SIGNED (SIGNED),
        .ROUND  (ROUND),
        .SAT    (SAT)
    ) u_sat (
        .i_p   (r_acc),
        .o_res (w_res),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_mcand    <= w_mext;
                        r_mplier   <= io_bus.in2;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_out       <= w_res;
                    r_ovf       <= w_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out       = r_out;
    assign io_bus.ovf       = r_ovf;
    assign io_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for multiplicador_secuencial: vector table plus
// handshake stall and mid-operation reset sequences.
module tb_multiplicador_secuencial;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multiplicador_secuencial_if #(.W1(24), .W2(12), .WO(12)) bus ();
    multiplicador_secuencial_if #(.W1(24), .W2(12), .WO(12)) bus_r0 ();

    multiplicador_secuencial dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    multiplicador_secuencial #(.ROUND(0)) dut_r0 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [11:0] b;
        logic [11:0] o;
        logic        v;
        logic [11:0] o0;
        logic        v0;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [35:0] got,
                       input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [23:0] a, input logic [11:0] b,
                          input logic v);
        bus.in1 = a;
        bus.in2 = b;
        bus.in_valid = v;
        bus_r0.in1 = a;
        bus_r0.in2 = b;
        bus_r0.in_valid = v;
    endtask

    task automatic set_ordy(input logic r);
        bus.out_ready = r;
        bus_r0.out_ready = r;
    endtask

    task automatic start_op(input logic [23:0] a, input logic [11:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_wait", {35'd0, bus.in_ready}, 36'd1);
        set_in(a, b, 1'b1);
        step();
        // Scramble operands after acceptance; they must not matter.
        set_in(24'($urandom), 12'($urandom), 1'b0);
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic consume();
        set_ordy(1'b1);
        step();
        set_ordy(1'b0);
        chk("post_consume_in_ready", {35'd0, bus.in_ready}, 36'd1);
        chk("post_consume_out_valid", {35'd0, bus.out_valid}, 36'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        start_op(v.a, v.b);
        wait_res(lat);
        chk({tag, "_latency"}, 36'(lat), 36'd13);
        chk({tag, "_valid_r0"}, {35'd0, bus_r0.out_valid}, 36'd1);
        chk({tag, "_out"}, {24'd0, bus.out}, {24'd0, v.o});
        chk({tag, "_ovf"}, {35'd0, bus.ovf}, {35'd0, v.v});
        chk({tag, "_out_r0"}, {24'd0, bus_r0.out}, {24'd0, v.o0});
        chk({tag, "_ovf_r0"}, {35'd0, bus_r0.ovf}, {35'd0, v.v0});
        consume();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vt[0] = '{24'd4096,   12'd100,  12'd100,  1'b0, 12'd100,  1'b0};
        vt[1] = '{24'hFFF000, 12'd100,  12'hF9C,  1'b0, 12'hF9C,  1'b0};
        vt[2] = '{24'hFFF000, 12'h800,  12'h7FF,  1'b1, 12'h7FF,  1'b1};
        vt[3] = '{24'h7FFFFF, 12'h7FF,  12'h7FF,  1'b1, 12'h7FF,  1'b1};
        vt[4] = '{24'h800000, 12'h7FF,  12'h800,  1'b1, 12'h800,  1'b1};
        vt[5] = '{24'd2048,   12'd1,    12'd1,    1'b0, 12'd0,    1'b0};
        vt[6] = '{24'd2047,   12'd1,    12'd0,    1'b0, 12'd0,    1'b0};
        vt[7] = '{24'hFFF800, 12'd1,    12'd0,    1'b0, 12'hFFF,  1'b0};
        vt[8] = '{24'h123456, 12'd0,    12'd0,    1'b0, 12'd0,    1'b0};
        vt[9] = '{24'd8192,   12'd1023, 12'h7FE,  1'b0, 12'h7FE,  1'b0};

        rst = 1'b1;
        set_in('0, '0, 1'b0);
        set_ordy(1'b0);
        step();
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", {35'd0, bus.in_ready}, 36'd1);
        chk("reset_out_valid", {35'd0, bus.out_valid}, 36'd0);
        chk("reset_out", {24'd0, bus.out}, 36'd0);
        chk("reset_ovf", {35'd0, bus.ovf}, 36'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Stall in DONE; new operands offered meanwhile must be ignored.
        start_op(24'h7FFFFF, 12'h7FF);
        begin
            int lat;
            wait_res(lat);
            chk("stall_latency", 36'(lat), 36'd13);
        end
        for (int i = 0; i < 20; i++) begin
            set_in(24'd4096, 12'd5, 1'b1);
            step();
            chk("stall_out", {24'd0, bus.out}, 36'h7FF);
            chk("stall_ovf", {35'd0, bus.ovf}, 36'd1);
            chk("stall_valid", {35'd0, bus.out_valid}, 36'd1);
            chk("stall_in_ready", {35'd0, bus.in_ready}, 36'd0);
        end
        set_in('0, '0, 1'b0);
        consume();
        step();
        chk("idle_after_stall", {35'd0, bus.out_valid}, 36'd0);

        // Abort mid-CALC; out currently holds 7FF from the stalled op.
        start_op(24'd4096, 12'd100);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("abort_out_valid", {35'd0, bus.out_valid}, 36'd0);
        chk("abort_out", {24'd0, bus.out}, 36'd0);
        chk("abort_ovf", {35'd0, bus.ovf}, 36'd0);
        chk("abort_in_ready", {35'd0, bus.in_ready}, 36'd1);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("abort_no_result", {35'd0, bus.out_valid}, 36'd0);
        end

        run_vec(vt[1], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
